mul_sequencer: RTL and testbench

Multi-cycle controller for the execute-stage multiplier. It executes MUL, MLA, UMULL and SMULL on an iterative radix-2 shift-add datapath. While an operation runs it stalls the pipeline, and it presents the result and NZ flag update to writeback with a one-cycle Done pulse. The condition unit gates Start, so only condition-passed multiplies reach this block.

---
 rtl/mul_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mul_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier controller for MUL/MLA/UMULL/SMULL.
// Latency: WIDTH+2 cycles from the accepted Start cycle to the one-cycle Done pulse.
// Backpressure: Busy stalls F/D/E while an operation runs; Start during RUN is ignored (request held upstream).
//
// Ports:
//   CLK, RESET             rising-edge clock, asynchronous active-high reset
//   Start                  condition-passed multiply request (E stage)
//   Accumulate/Long/Signed/SetFlags  operation mode bits (MLA / long / SMULL / S bit)
//   SrcA, SrcB, AccIn      multiplicand, multiplier, accumulate operand
//   FlagsIn                current {N,Z,C,V}
//   FlushE                 squash E stage; wins over Start
//   Busy                   combinational stall request
//   Done                   one-cycle result-valid pulse
//   ResultLo, ResultHi     product low/high halves (high half is 0 for non-long ops)
//   FlagsOut, FlagWrite    {N,Z,C,V} for writeback, write enable valid only with Done
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             Accumulate,
    input  logic             Long,
    input  logic             Signed,
    input  logic             SetFlags,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] AccIn,
    input  logic [3:0]       FlagsIn,
    input  logic             FlushE,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       FlagsOut,
    output logic             FlagWrite
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Datapath state
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_q, long_d;
    logic             neg_q, neg_d;
    logic             set_flags_q, set_flags_d;
    logic [1:0]       cv_q, cv_d;

    // Result registers held until the next completed operation
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             last_iter;
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    step_sum;
    logic [PW-1:0]    final_prod;
    logic             n_flag, z_flag;

    // Only C and V are carried through; N and Z are recomputed from the product.
    logic             unused_flags_in;
    assign unused_flags_in = ^FlagsIn[3:2];

    // A new request is taken from IDLE or DONE (back-to-back), never while running.
    assign accept    = Start & ~FlushE & (state_q != S_RUN);
    assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // Signed long multiplies run on magnitudes. The unsigned reading of the
    // negated most-negative value is exactly 2^(WIDTH-1), so no special case.
    assign signed_op = Long & Signed;
    assign a_neg     = signed_op & SrcA[WIDTH-1];
    assign b_neg     = signed_op & SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;

    // One shift-add iteration and the sign-corrected product it would finish with.
    assign step_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign final_prod = neg_q ? -step_sum : step_sum;
    assign n_flag     = long_q ? final_prod[PW-1] : final_prod[WIDTH-1];
    assign z_flag     = long_q ? (final_prod == '0) : (final_prod[WIDTH-1:0] == '0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (FlushE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = Start ? S_RUN : S_IDLE;
                S_RUN:   state_d = last_iter ? S_DONE : S_RUN;
                S_DONE:  state_d = Start ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        Busy      = (state_q == S_RUN) | (Start & (state_q != S_RUN) & ~FlushE);
        Done      = (state_q == S_DONE);
        FlagWrite = (state_q == S_DONE) & set_flags_q;
    end

    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign FlagsOut = flags_q;

    // ---------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------
    always_comb begin
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        long_d      = long_q;
        neg_d       = neg_q;
        set_flags_d = set_flags_q;
        cv_d        = cv_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        flags_d     = flags_q;

        if (accept) begin
            mcand_d     = {{WIDTH{1'b0}}, a_mag};
            mplier_d    = b_mag;
            acc_d       = Accumulate ? {{WIDTH{1'b0}}, AccIn} : '0;
            cnt_d       = '0;
            long_d      = Long;
            neg_d       = a_neg ^ b_neg;
            set_flags_d = SetFlags;
            cv_d        = FlagsIn[1:0];
        end else if ((state_q == S_RUN) && !FlushE) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Results are captured on the final iteration so they are
            // stable throughout the DONE cycle. A flush skips this entirely.
            if (last_iter) begin
                res_lo_d = final_prod[WIDTH-1:0];
                res_hi_d = long_q ? final_prod[PW-1:WIDTH] : '0;
                flags_d  = {n_flag, z_flag, cv_q};
            end
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            long_q      <= 1'b0;
            neg_q       <= 1'b0;
            set_flags_q <= 1'b0;
            cv_q        <= '0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            flags_q     <= '0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            long_q      <= long_d;
            neg_q       <= neg_d;
            set_flags_q <= set_flags_d;
            cv_q        <= cv_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized bench for mul_sequencer against an arithmetic product model.
// Latency: checks Done arrives WIDTH+2 cycles after the Start cycle.
// Backpressure: checks Busy over the whole operation, flush and reset aborts.
module tb_mul_sequencer;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Start, Accumulate, Long, Signed, SetFlags, FlushE;
    logic [W-1:0]  SrcA, SrcB, AccIn;
    logic [3:0]    FlagsIn;
    logic          Busy, Done, FlagWrite;
    logic [W-1:0]  ResultLo, ResultHi;
    logic [3:0]    FlagsOut;

    always #5 CLK = ~CLK;

    mul_sequencer #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Start     (Start),
        .Accumulate(Accumulate),
        .Long      (Long),
        .Signed    (Signed),
        .SetFlags  (SetFlags),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .AccIn     (AccIn),
        .FlagsIn   (FlagsIn),
        .FlushE    (FlushE),
        .Busy      (Busy),
        .Done      (Done),
        .ResultLo  (ResultLo),
        .ResultHi  (ResultHi),
        .FlagsOut  (FlagsOut),
        .FlagWrite (FlagWrite)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results of the operation most recently started
    logic [W-1:0] exp_lo, exp_hi;
    logic [3:0]   exp_flags;
    logic         exp_fw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scramble every input except Start/FlushE/RESET so latching is exercised.
    task automatic scramble();
        SrcA       = $urandom;
        SrcB       = $urandom;
        AccIn      = $urandom;
        FlagsIn    = 4'($urandom);
        Accumulate = 1'($urandom);
        Long       = 1'($urandom);
        Signed     = 1'($urandom);
        SetFlags   = 1'($urandom);
    endtask

    // Drive a request for this cycle and compute the expected outcome from
    // the instruction semantics with plain wide arithmetic.
    task automatic start_op(input logic acc, input logic lng, input logic sgn, input logic sf,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [3:0] fl);
        logic [63:0] p;
        logic [31:0] lo32;
        Start = 1'b1; FlushE = 1'b0;
        Accumulate = acc; Long = lng; Signed = sgn; SetFlags = sf;
        SrcA = a; SrcB = b; AccIn = c; FlagsIn = fl;
        if (lng) begin
            if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else     p = {32'd0, a} * {32'd0, b};
        end else begin
            lo32 = a * b + (acc ? c : 32'd0);
            p    = {32'd0, lo32};
        end
        exp_lo    = p[31:0];
        exp_hi    = p[63:32];
        exp_flags = {lng ? p[63] : p[31], lng ? (p == 64'd0) : (p[31:0] == 32'd0), fl[1:0]};
        exp_fw    = sf;
        #1;
        check("busy_start", 64'(Busy), 64'd1);
    endtask

    // Wait (bounded) for Done, then check latency, Busy span and results.
    task automatic wait_done(input string tag);
        int cyc;
        int busy_n;
        bit got;
        cyc = 1; busy_n = 1; got = 0;
        for (int k = 0; k < 3 * W && !got; k++) begin
            @(posedge CLK); #1;
            Start = 1'b0;
            scramble();
            #1;
            cyc++;
            if (Done) got = 1;
            else if (Busy) busy_n++;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(W + 2));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
        check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
        check({tag, "_lo"}, 64'(ResultLo), 64'(exp_lo));
        check({tag, "_hi"}, 64'(ResultHi), 64'(exp_hi));
        check({tag, "_flags"}, 64'(FlagsOut), 64'(exp_flags));
        check({tag, "_flagwrite"}, 64'(FlagWrite), 64'(exp_fw));
    endtask

    // One cycle after Done: pulse ended, results held.
    task automatic post_tick(input string tag);
        @(posedge CLK); #1;
        Start = 1'b0;
        #1;
        check({tag, "_done_pulse"}, 64'(Done), 64'd0);
        check({tag, "_fw_after"}, 64'(FlagWrite), 64'd0);
        check({tag, "_lo_hold"}, 64'(ResultLo), 64'(exp_lo));
    endtask

    // Run n idle cycles, counting Done and Busy highs.
    task automatic quiet_cycles(input int n, output int done_n, output int busy_n);
        done_n = 0; busy_n = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #2;
            if (Done) done_n++;
            if (Busy) busy_n++;
        end
    endtask

    logic [W-1:0] prev_lo, prev_hi;
    logic         r_lng, r_sgn, r_acc;
    logic [W-1:0] r_a, r_b, r_c;
    int           d_n, b_n;

    initial begin
        RESET = 1'b1; Start = 1'b0; FlushE = 1'b0;
        Accumulate = 1'b0; Long = 1'b0; Signed = 1'b0; SetFlags = 1'b0;
        SrcA = '0; SrcB = '0; AccIn = '0; FlagsIn = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #2;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_lo", 64'(ResultLo), 64'd0);
        check("rst_hi", 64'(ResultHi), 64'd0);
        check("rst_flags", 64'(FlagsOut), 64'd0);
        check("rst_fw", 64'(FlagWrite), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #2;

        // MUL 7*6
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd99, 4'b0000);
        wait_done("mul7x6");
        post_tick("mul7x6");

        // MLA with S bit: 3*4+5, C=1 V=0
        start_op(1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 32'd5, 4'b1110);
        wait_done("mla");
        post_tick("mla");

        // MUL with S bit, zero product
        start_op(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd9, 32'd0, 4'b0001);
        wait_done("mul_zero");
        post_tick("mul_zero");

        // UMULL all-ones squared
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b0000);
        wait_done("umull_max");
        post_tick("umull_max");

        // SMULL -2*3
        start_op(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'd0, 4'b0011);
        wait_done("smull_neg");
        post_tick("smull_neg");

        // SMULL most-negative squared
        start_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 4'b0000);
        wait_done("smull_minsq");
        post_tick("smull_minsq");

        // Flush at iteration 10: abort, no Done, results unchanged
        prev_lo = exp_lo; prev_hi = exp_hi;
        start_op(1'b0, 1'b0, 1'b0, 1'b1, 32'd123, 32'd456, 32'd0, 4'b0000);
        repeat (10) begin
            @(posedge CLK); #1;
            Start = 1'b0;
        end
        FlushE = 1'b1;
        #1;
        check("flush_busy_run", 64'(Busy), 64'd1);
        @(posedge CLK); #1;
        FlushE = 1'b0;
        #1;
        check("flush_busy_after", 64'(Busy), 64'd0);
        check("flush_done_after", 64'(Done), 64'd0);
        check("flush_lo_kept", 64'(ResultLo), 64'(prev_lo));
        check("flush_hi_kept", 64'(ResultHi), 64'(prev_hi));
        quiet_cycles(W + 8, d_n, b_n);
        check("flush_no_done", 64'(d_n), 64'd0);
        check("flush_no_busy", 64'(b_n), 64'd0);

        // Start together with FlushE is not accepted
        Start = 1'b1; FlushE = 1'b1; SrcA = 32'd5; SrcB = 32'd5;
        #1;
        check("startflush_busy", 64'(Busy), 64'd0);
        @(posedge CLK); #1;
        Start = 1'b0; FlushE = 1'b0;
        quiet_cycles(W + 8, d_n, b_n);
        check("startflush_no_done", 64'(d_n), 64'd0);
        check("startflush_no_busy", 64'(b_n), 64'd0);

        // Back-to-back: new Start accepted in the DONE cycle
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 4'b0000);
        wait_done("b2b_first");
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 4'b0010);
        wait_done("b2b_second");
        post_tick("b2b_second");

        // Reset mid-RUN: outputs cleared, no Done afterwards
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, 4'b0011);
        repeat (5) begin
            @(posedge CLK); #1;
            Start = 1'b0;
        end
        RESET = 1'b1;
        #1;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_lo", 64'(ResultLo), 64'd0);
        check("midrst_hi", 64'(ResultHi), 64'd0);
        check("midrst_flags", 64'(FlagsOut), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        quiet_cycles(W + 8, d_n, b_n);
        check("midrst_no_done", 64'(d_n), 64'd0);
        check("midrst_no_busy", 64'(b_n), 64'd0);

        // First Start after reset release behaves normally
        start_op(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0001);
        wait_done("after_rst");
        post_tick("after_rst");

        // Randomized operations across all modes
        for (int i = 0; i < 16; i++) begin
            r_lng = 1'($urandom);
            r_sgn = 1'($urandom);
            r_acc = r_lng ? 1'b0 : 1'($urandom);
            r_a   = $urandom;
            r_b   = $urandom;
            r_c   = $urandom;
            if (i % 4 == 0) r_a = 32'h8000_0000;
            if (i % 5 == 0) r_b = 32'd0;
            if (i % 7 == 3) r_b = 32'hFFFF_FFFF;
            start_op(r_acc, r_lng, r_sgn, 1'($urandom), r_a, r_b, r_c, 4'($urandom));
            wait_done("rnd");
            if (i % 3 == 0) post_tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
